alu_mdu_unit: RTL and testbench
===============================

ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (allowed 8..64, even).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have ports ALUop [1:0], funct3 [2:0], funct7_5, funct7_0, op_5 as inputs: instruction decode fields.
REQ-007 SHALL have ports src_a, src_b  input  XLEN  operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port result  output  XLEN  registered result.
REQ-011 SHALL have ports zero and illegal  output  1 each: result==0 and undecodable request, both qualified by out_valid.
REQ-012 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE); request accepted when in_valid & in_ready.
REQ-014 Decode SHALL be: ALUop 00 add; 01 sub; 11 illegal (result 0, illegal=1); 10 by funct3: 000 add, or sub when op_5&funct7_5; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when funct7_5; 110 or; 111 and.
REQ-015 Shift amount SHALL be src_b[$clog2(XLEN)-1:0]; add/sub wrap modulo 2^XLEN; slt signed, sltu unsigned, result 0 or 1.
REQ-016 Single-cycle ops: accepted in cycle N -> DONE, out_valid=1 in cycle N+1.
REQ-017 In DONE, result/zero/illegal SHALL hold stable until out_ready=1; that cycle returns to IDLE, out_valid deasserts next cycle.
REQ-018 in_valid during DONE, even with out_ready=1, SHALL NOT be accepted; earliest accept is the following IDLE cycle.
REQ-019 Requests arriving when in_ready=0 SHALL be ignored and not queued.

Reset
REQ-020 While rst_n=0 at a clock edge: state IDLE, out_valid 0, result 0, zero 0, illegal 0, busy 0, internal iteration registers 0.
REQ-021 in_ready SHALL be 0 while rst_n=0, and 1 in the first cycle after release.
REQ-022 Reset during CALC or DONE SHALL abort the operation; no out_valid for it afterwards.

Configuration
REQ-023 Macro ALU_MDU_UNIT_MDU_EN SHALL compile in the M-extension path; absent, no multiplier/divider logic is present.
REQ-024 With macro: ALUop 10 & op_5 & funct7_0 SHALL select by funct3 mul, mulh, mulhsu, mulhu, div, divu, rem, remu (RISC-V semantics).
REQ-025 With macro: M ops SHALL enter CALC, busy=1, iterative shift-add / restoring divide, exactly XLEN cycles; accept at N -> out_valid at N+XLEN+1.
REQ-026 With macro: divide by zero SHALL give quotient all-ones and remainder src_a; signed overflow (min / -1) SHALL give quotient src_a and remainder 0; both keep full latency.
REQ-027 Without macro: that encoding SHALL complete as single-cycle with result 0, illegal=1.

Verification
REQ-028 XLEN=32, ALUop=10, funct3=000, op_5=1, funct7_5=1, a=5, b=7 -> out_valid next cycle, result 0xFFFFFFFE, zero 0.
REQ-029 ALUop=10, funct3=101, funct7_5=1, a=0x80000000, b=4 -> result 0xF8000000; with funct7_5=0 -> 0x08000000.
REQ-030 MDU_EN, div a=0xFFFFFFF9 (-7), b=2 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFD; busy high 32 cycles.
REQ-031 MDU_EN, divu b=0 -> 0xFFFFFFFF; rem a=0x80000000, b=0xFFFFFFFF -> 0.
REQ-032 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> result stable, in_ready 0, no new accept; accept occurs the cycle after out_ready pulse.
REQ-033 Assert rst_n=0 at CALC cycle 10 of a mul -> out_valid never rises for it; in_ready=1 one cycle after release.

Source files
------------

// File: rtl/alu_mdu_unit.sv
// Handshaked integer ALU with an optional iterative multiply/divide unit.
// Define ALU_MDU_UNIT_MDU_EN to build the M-extension (shift-add / restoring divide) path.
module alu_mdu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUop,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic            op_5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            is_m_enc;
  logic            start_mdu;
  logic            mdu_last;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic [XLEN-1:0] result_q;
  logic            illegal_q;

  assign accept   = in_valid & in_ready;
  assign is_m_enc = (ALUop == 2'b10) & op_5 & funct7_0;
  assign shamt    = src_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUop)
      2'b00: alu_res = src_a + src_b;
      2'b01: alu_res = src_a - src_b;
      2'b10: begin
        case (funct3)
          3'b000: alu_res = (op_5 & funct7_5) ? (src_a - src_b) : (src_a + src_b);
          3'b001: alu_res = src_a << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
          3'b100: alu_res = src_a ^ src_b;
          3'b101: alu_res = funct7_5 ? XLEN'($signed(src_a) >>> shamt) : (src_a >> shamt);
          3'b110: alu_res = src_a | src_b;
          3'b111: alu_res = src_a & src_b;
        endcase
      end
      default: alu_ill = 1'b1;
    endcase
    // M encodings are only legal when the iterative unit is built; otherwise flagged here.
    if (is_m_enc) begin
      alu_res = '0;
      alu_ill = 1'b1;
    end
  end

`ifdef ALU_MDU_UNIT_MDU_EN
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [SW-1:0]     cnt;
  logic [2:0]        m_op;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   hi_next;
  logic [XLEN-1:0]   lo_next;
  logic [XLEN-1:0]   mdu_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] prod;

  // Unsigned magnitude datapath; signs are reapplied to the final result.
  always_comb begin
    a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg = a_sgn & src_a[XLEN-1];
    b_neg = b_sgn & src_b[XLEN-1];
    mag_a = a_neg ? -src_a : src_a;
    mag_b = b_neg ? -src_b : src_b;
  end

  assign start_mdu = accept & is_m_enc;
  assign mdu_last  = (state == CALC) && (cnt == SW'(XLEN-1));

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, mcand};
    if (m_op[2]) begin
      hi_next = div_ge ? XLEN'(div_shift - {1'b0, mcand}) : div_shift[XLEN-1:0];
      lo_next = {acc_lo[XLEN-2:0], div_ge};
    end else begin
      hi_next = mul_sum[XLEN:1];
      lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod = {hi_next, lo_next};
    if (neg_res) prod = -prod;
    // Divide by zero falls out naturally: all-ones quotient, remainder equal to the dividend.
    case (m_op)
      3'b000:                 mdu_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: mdu_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         mdu_res = neg_res ? -lo_next : lo_next;
      default:                mdu_res = neg_rem ? -hi_next : hi_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      m_op    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
    end else if (start_mdu) begin
      cnt     <= '0;
      m_op    <= funct3;
      neg_res <= funct3[2] ? ((a_neg ^ b_neg) & (|src_b)) : (a_neg ^ b_neg);
      neg_rem <= a_neg;
      acc_hi  <= '0;
      acc_lo  <= funct3[2] ? mag_a : mag_b;
      mcand   <= funct3[2] ? mag_b : mag_a;
    end else if (state == CALC) begin
      cnt    <= cnt + SW'(1);
      acc_hi <= hi_next;
      acc_lo <= lo_next;
    end
  end
`else
  assign start_mdu = 1'b0;
  assign mdu_last  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = start_mdu ? CALC : DONE;
      CALC:    if (mdu_last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n & (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == CALC);
    result    = result_q;
    zero      = out_valid & (result_q == '0);
    illegal   = out_valid & illegal_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept && !start_mdu) begin
      result_q  <= alu_res;
      illegal_q <= alu_ill;
    end
`ifdef ALU_MDU_UNIT_MDU_EN
    else if (mdu_last) begin
      result_q  <= mdu_res;
      illegal_q <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed self-checking bench for alu_mdu_unit (XLEN=32).
// The multiply/divide scenarios are built only when ALU_MDU_UNIT_MDU_EN is defined.
module tb_alu_mdu_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUop;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        funct7_0;
  logic        op_5;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic        o5;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t vecs [14];

  alu_mdu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0), .op_5(op_5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for a single cycle; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                      input logic f70, input logic o5, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUop = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op_5 = o5;
    src_a = a; src_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    ALUop = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0; op_5 = 1'b0;
    src_a = 32'd9; src_b = 32'd9;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); else pass_cnt++;
    chk_cnt++; if (result !== 32'h0) $display("[TB] FAIL reset_result got %h expected 00000000", result); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b expected 0", in_ready); else pass_cnt++;
    chk_cnt++; if ({zero, illegal} !== 2'b00) $display("[TB] FAIL reset_flags got %b expected 00", {zero, illegal}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready got %b expected 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_alu;
    vecs[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[4]  = '{2'b10, 3'b001, 1'b0, 1'b0, 32'd1,        32'h23,       32'd8,        1'b0};
    vecs[5]  = '{2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    vecs[6]  = '{2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    vecs[7]  = '{2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    vecs[8]  = '{2'b10, 3'b101, 1'b1, 1'b0, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
    vecs[9]  = '{2'b10, 3'b101, 1'b0, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0};
    vecs[10] = '{2'b10, 3'b110, 1'b0, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0};
    vecs[11] = '{2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[12] = '{2'b11, 3'b000, 1'b0, 1'b0, 32'd5,        32'd7,        32'd0,        1'b1};
    vecs[13] = '{2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].op, vecs[i].f3, vecs[i].f75, 1'b0, vecs[i].o5, vecs[i].a, vecs[i].b);
      chk_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL alu_out_valid[%0d] got %b expected 1", i, out_valid); else pass_cnt++;
      chk_cnt++; if (result !== vecs[i].exp) $display("[TB] FAIL alu_result[%0d] got %h expected %h", i, result, vecs[i].exp); else pass_cnt++;
      chk_cnt++; if (zero !== (vecs[i].exp == 32'h0)) $display("[TB] FAIL alu_zero[%0d] got %b expected %b", i, zero, vecs[i].exp == 32'h0); else pass_cnt++;
      chk_cnt++; if (illegal !== vecs[i].ill) $display("[TB] FAIL alu_illegal[%0d] got %b expected %b", i, illegal, vecs[i].ill); else pass_cnt++;
      consume();
      chk_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL alu_drop_valid[%0d] got %b expected 0", i, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_hold;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
    src_a = 32'd100; src_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_cnt++; if (result !== 32'd7) $display("[TB] FAIL hold_result[%0d] got %h expected 00000007", i, result); else pass_cnt++;
      chk_cnt++; if ({out_valid, in_ready} !== 2'b10) $display("[TB] FAIL hold_handshake[%0d] got %b expected 10", i, {out_valid, in_ready}); else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_cnt++; if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL hold_release got %b expected 01", {out_valid, in_ready}); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL hold_next_valid got %b expected 1", out_valid); else pass_cnt++;
    chk_cnt++; if (result !== 32'd101) $display("[TB] FAIL hold_next_result got %h expected 00000065", result); else pass_cnt++;
    consume();
  endtask

  task automatic test_reset_abort_done;
    bit seen;
    send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if ({out_valid, in_ready} !== 2'b00) $display("[TB] FAIL abort_done_handshake got %b expected 00", {out_valid, in_ready}); else pass_cnt++;
    chk_cnt++; if (result !== 32'h0) $display("[TB] FAIL abort_done_result got %h expected 00000000", result); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL abort_done_ready got %b expected 1", in_ready); else pass_cnt++;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk_cnt++; if (seen !== 1'b0) $display("[TB] FAIL abort_done_stale_valid got %b expected 0", seen); else pass_cnt++;
  endtask

`ifdef ALU_MDU_UNIT_MDU_EN
  task automatic run_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int bcnt);
    send(2'b10, f3, 1'b0, 1'b1, 1'b1, a, b);
    cyc = 1; bcnt = 0;
    while (!out_valid && cyc < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_mdu;
    logic [2:0]  f3s [10] = '{3'b100, 3'b101, 3'b110, 3'b100, 3'b110, 3'b000, 3'b001, 3'b011, 3'b010, 3'b111};
    logic [31:0] as  [10] = '{32'hFFFFFFF9, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9,
                              32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd17};
    logic [31:0] bs  [10] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                              32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    logic [31:0] es  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFF9,
                              32'hFFFFFFF1, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd2};
    int cyc;
    int bcnt;
    for (int i = 0; i < 10; i++) begin
      run_mdu(f3s[i], as[i], bs[i], cyc, bcnt);
      chk_cnt++; if (cyc !== 33) $display("[TB] FAIL mdu_latency[%0d] got %0d expected 33", i, cyc); else pass_cnt++;
      chk_cnt++; if (bcnt !== 32) $display("[TB] FAIL mdu_busy[%0d] got %0d expected 32", i, bcnt); else pass_cnt++;
      chk_cnt++; if (result !== es[i]) $display("[TB] FAIL mdu_result[%0d] got %h expected %h", i, result, es[i]); else pass_cnt++;
      chk_cnt++; if (illegal !== 1'b0) $display("[TB] FAIL mdu_illegal[%0d] got %b expected 0", i, illegal); else pass_cnt++;
      consume();
    end
  endtask

  task automatic test_reset_abort_calc;
    bit seen;
    send(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if ({busy, in_ready} !== 2'b00) $display("[TB] FAIL abort_calc_state got %b expected 00", {busy, in_ready}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL abort_calc_ready got %b expected 1", in_ready); else pass_cnt++;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk_cnt++; if (seen !== 1'b0) $display("[TB] FAIL abort_calc_stale_valid got %b expected 0", seen); else pass_cnt++;
  endtask
`else
  task automatic test_m_disabled;
    send(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd20, 32'd4);
    chk_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL m_off_valid got %b expected 1", out_valid); else pass_cnt++;
    chk_cnt++; if (result !== 32'h0) $display("[TB] FAIL m_off_result got %h expected 00000000", result); else pass_cnt++;
    chk_cnt++; if (illegal !== 1'b1) $display("[TB] FAIL m_off_illegal got %b expected 1", illegal); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL m_off_busy got %b expected 0", busy); else pass_cnt++;
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_hold();
    test_reset_abort_done();
`ifdef ALU_MDU_UNIT_MDU_EN
    test_mdu();
    test_reset_abort_calc();
`else
    test_m_disabled();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
